// File: rtl/systolic_output_collector.sv
// systolic_output_collector
//   Drain-side result collector for an N x N systolic array. It captures the
//   result words leaving the N bottom-edge PEs, using per-column valid/last
//   strobes. Words go into an N*N result buffer laid out like the input queue:
//   column c, element k lives at address c + N*k. A registered read port lets
//   the host or next stage fetch results.
//
// Ports
//   clk_i           clock
//   rstn_i          asynchronous active-low reset
//   start_i         arm a collection (clears counters, col_done, error flags)
//   data_i[0:N-1]   result words from the bottom-edge PEs
//   valid_i[N]      per-column result valid
//   last_i[N]       per-column last marker (qualified by valid_i)
//   rd_en_i         read request
//   rd_addr_i       read address
//   rd_data_o       read data, one cycle after rd_en_i
//   rd_valid_o      strobe for rd_data_o
//   busy_o          high while collecting
//   done_o          one-cycle pulse when every column has completed
//   col_done_o[N]   per-column complete flags
//   overflow_err_o  sticky: a word arrived on a column that was already complete
//   length_err_o    sticky: last_i arrived with a count other than N-1
module systolic_output_collector #(
  parameter int N           = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = $clog2(N*N),
  parameter int COUNT_WIDTH = $clog2(N+1)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] data_i [0:N-1],
  input  logic [N-1:0]          valid_i,
  input  logic [N-1:0]          last_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [N-1:0]          col_done_o,
  output logic                  overflow_err_o,
  output logic                  length_err_o
);

  localparam int DEPTH = N * N;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t                  state, state_nxt;
  logic [COUNT_WIDTH-1:0]  count [0:N-1];
  logic [N-1:0]            wr_en;
  logic [N-1:0]            col_done_nxt;
  logic [ADDR_WIDTH-1:0]   wr_addr [0:N-1];
  logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];
  logic                    collecting;
  logic                    arm;
  logic                    rd_in_range;

  assign collecting = (state == COLLECT);
  // start_i only has an effect outside COLLECT.
  assign arm = start_i && !collecting;

  // Per-column capture decode. A column accepts a word only while collecting
  // and not yet complete; col_done_nxt folds in completions from this cycle so
  // the FSM can leave COLLECT in the same cycle the final column finishes.
  always_comb begin
    wr_en        = '0;
    col_done_nxt = col_done_o;
    for (int c = 0; c < N; c++) begin
      wr_addr[c] = ADDR_WIDTH'(c) + ADDR_WIDTH'(N) * ADDR_WIDTH'(count[c]);
      wr_en[c]   = collecting && valid_i[c] && !col_done_o[c];
      if (wr_en[c] && ((count[c] == COUNT_WIDTH'(N-1)) || last_i[c]))
        col_done_nxt[c] = 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = COLLECT;
      COLLECT: if (&col_done_nxt) state_nxt = DONE;
      DONE:    if (start_i) state_nxt = COLLECT;
      default: state_nxt = IDLE;
    endcase
  end

  // State, status flags and per-column counters. Arming clears everything
  // except the buffer; otherwise counters advance on accepted words and the
  // error flags stick until the next arm or reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state          <= IDLE;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      col_done_o     <= '0;
      overflow_err_o <= 1'b0;
      length_err_o   <= 1'b0;
      for (int c = 0; c < N; c++) count[c] <= '0;
    end else begin
      state  <= state_nxt;
      busy_o <= (state_nxt == COLLECT);
      done_o <= collecting && (state_nxt == DONE);
      if (arm) begin
        col_done_o     <= '0;
        overflow_err_o <= 1'b0;
        length_err_o   <= 1'b0;
        for (int c = 0; c < N; c++) count[c] <= '0;
      end else begin
        col_done_o <= col_done_nxt;
        for (int c = 0; c < N; c++) begin
          if (wr_en[c]) begin
            count[c] <= count[c] + COUNT_WIDTH'(1);
            if (last_i[c] && (count[c] != COUNT_WIDTH'(N-1)))
              length_err_o <= 1'b1;
          end
          if (collecting && valid_i[c] && col_done_o[c])
            overflow_err_o <= 1'b1;
        end
      end
    end
  end

  // Result buffer: N write ports with distinct addresses, never reset.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < N; c++) begin
      if (wr_en[c]) mem[wr_addr[c]] <= data_i[c];
    end
  end

  // Addresses past the buffer read as zero. When the buffer fills the whole
  // address space every address is in range.
  if (DEPTH == (1 << ADDR_WIDTH)) begin : g_full_range
    assign rd_in_range = 1'b1;
  end else begin : g_part_range
    assign rd_in_range = (int'(rd_addr_i) < DEPTH);
  end

  // Registered read port; reads see the contents before any same-cycle write.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_valid_o <= rd_en_i;
      if (rd_en_i) rd_data_o <= rd_in_range ? mem[rd_addr_i] : '0;
    end
  end

endmodule

// File: tb/tb_systolic_output_collector.sv
// tb_systolic_output_collector
//   Directed bench for systolic_output_collector at N=4, 16-bit words.
//   Reads push their expected data into a queue; a monitor pops and compares
//   whenever rd_valid_o is seen. Status flags are compared directly after
//   each driven cycle.
module tb_systolic_output_collector;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          start_i;
  logic [DW-1:0] data_i [0:N-1];
  logic [N-1:0]  valid_i;
  logic [N-1:0]  last_i;
  logic          rd_en_i;
  logic [AW-1:0] rd_addr_i;
  logic [DW-1:0] rd_data_o;
  logic          rd_valid_o;
  logic          busy_o;
  logic          done_o;
  logic [N-1:0]  col_done_o;
  logic          overflow_err_o;
  logic          length_err_o;

  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] stim_data [0:N-1];

  systolic_output_collector #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .start_i        (start_i),
    .data_i         (data_i),
    .valid_i        (valid_i),
    .last_i         (last_i),
    .rd_en_i        (rd_en_i),
    .rd_addr_i      (rd_addr_i),
    .rd_data_o      (rd_data_o),
    .rd_valid_o     (rd_valid_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .col_done_o     (col_done_o),
    .overflow_err_o (overflow_err_o),
    .length_err_o   (length_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard monitor: every rd_valid_o must match the oldest pending read.
  always @(negedge clk_i) begin
    if (rstn_i && rd_valid_o) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL rd_unexpected: got rd_valid_o with data %h, no read pending", rd_data_o);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (rd_data_o !== e) begin
          bad++;
          $display("[TB] FAIL rd_data: got %h, expected %h", rd_data_o, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive one cycle of column strobes with stim_data, then return to idle.
  task automatic apply_stimulus(input logic [N-1:0] v, input logic [N-1:0] l);
    for (int c = 0; c < N; c++) data_i[c] = stim_data[c];
    valid_i = v;
    last_i  = l;
    tick();
    valid_i = '0;
    last_i  = '0;
    rd_en_i = 1'b0;
  endtask

  // Fill stim_data with base + k + 0x100*c for every column at element k.
  task automatic set_uniform(input logic [DW-1:0] base, input int k);
    for (int c = 0; c < N; c++) stim_data[c] = base + DW'(k) + DW'(16'h100 * c);
  endtask

  task automatic arm();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic queue_read(input logic [AW-1:0] addr, input logic [DW-1:0] expected);
    rd_en_i   = 1'b1;
    rd_addr_i = addr;
    exp_q.push_back(expected);
  endtask

  task automatic issue_read(input logic [AW-1:0] addr, input logic [DW-1:0] expected);
    queue_read(addr, expected);
    tick();
    rd_en_i = 1'b0;
  endtask

  // Read the whole buffer expecting base + k + 0x100*c at address c + 4k.
  task automatic read_all(input logic [DW-1:0] base);
    for (int a = 0; a < N*N; a++)
      issue_read(AW'(a), base + DW'(a / N) + DW'(16'h100 * (a % N)));
  endtask

  logic [N-1:0] skew_cd [0:6];

  initial begin
    skew_cd = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
    rstn_i    = 1'b0;
    start_i   = 1'b0;
    valid_i   = '0;
    last_i    = '0;
    rd_en_i   = 1'b0;
    rd_addr_i = '0;
    for (int c = 0; c < N; c++) begin
      data_i[c]    = '0;
      stim_data[c] = '0;
    end
    #22;
    // Reset state.
    check_output("rst_rd_valid", 32'(rd_valid_o), 32'd0);
    check_output("rst_rd_data", 32'(rd_data_o), 32'd0);
    check_output("rst_busy", 32'(busy_o), 32'd0);
    check_output("rst_done", 32'(done_o), 32'd0);
    check_output("rst_col_done", 32'(col_done_o), 32'd0);
    check_output("rst_overflow", 32'(overflow_err_o), 32'd0);
    check_output("rst_length", 32'(length_err_o), 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    tick();

    // 1: aligned four-word stream on every column.
    $display("[TB] aligned stream");
    arm();
    check_output("t1_busy", 32'(busy_o), 32'd1);
    for (int k = 0; k < N; k++) begin
      set_uniform(16'h00C0, k);
      apply_stimulus(4'b1111, (k == 3) ? 4'b1111 : 4'b0000);
      check_output("t1_done", 32'(done_o), (k == 3) ? 32'd1 : 32'd0);
      check_output("t1_col_done", 32'(col_done_o), (k == 3) ? 32'hF : 32'h0);
    end
    check_output("t1_busy_after", 32'(busy_o), 32'd0);
    // Words in DONE are ignored and raise no error.
    for (int c = 0; c < N; c++) stim_data[c] = 16'hFFFF;
    apply_stimulus(4'b1111, 4'b0000);
    check_output("t1_done_pulse", 32'(done_o), 32'd0);
    check_output("t1_overflow", 32'(overflow_err_o), 32'd0);
    check_output("t1_length", 32'(length_err_o), 32'd0);
    read_all(16'h00C0);

    // 2: skewed (diagonal) arrival, column c starts c cycles late.
    $display("[TB] skewed stream");
    arm();
    for (int cyc = 0; cyc < 7; cyc++) begin
      logic [N-1:0] v, l;
      v = '0;
      l = '0;
      for (int c = 0; c < N; c++) begin
        int k;
        k = cyc - c;
        stim_data[c] = 16'h00D0 + DW'(k) + DW'(16'h100 * c);
        if (k >= 0 && k < N) begin
          v[c] = 1'b1;
          l[c] = (k == N-1);
        end
      end
      apply_stimulus(v, l);
      check_output("t2_col_done", 32'(col_done_o), 32'(skew_cd[cyc]));
      check_output("t2_done", 32'(done_o), (cyc == 6) ? 32'd1 : 32'd0);
    end
    issue_read(4'd0, 16'h00D0);
    issue_read(4'd7, 16'h03D1);
    issue_read(4'd15, 16'h03D3);

    // 3: extra word on column 2 after it completes.
    $display("[TB] overflow");
    arm();
    for (int cyc = 0; cyc < 5; cyc++) begin
      for (int c = 0; c < N; c++) begin
        int k;
        k = (c == 2) ? cyc : cyc - 1;
        stim_data[c] = 16'h00E0 + DW'(k) + DW'(16'h100 * c);
      end
      if (cyc == 4) stim_data[2] = 16'h0BAD;
      apply_stimulus((cyc == 0) ? 4'b0100 : 4'b1111,
                     (cyc == 3) ? 4'b0100 : ((cyc == 4) ? 4'b1011 : 4'b0000));
      if (cyc == 3) begin
        check_output("t3_col_done", 32'(col_done_o), 32'h4);
        check_output("t3_overflow_early", 32'(overflow_err_o), 32'd0);
      end
    end
    check_output("t3_done", 32'(done_o), 32'd1);
    check_output("t3_overflow", 32'(overflow_err_o), 32'd1);
    check_output("t3_length", 32'(length_err_o), 32'd0);
    issue_read(4'd2, 16'h02E0);
    issue_read(4'd6, 16'h02E1);
    issue_read(4'd10, 16'h02E2);
    issue_read(4'd14, 16'h02E3);

    // 4: early last on column 1 at its second word.
    $display("[TB] short column");
    arm();
    check_output("t4_overflow_cleared", 32'(overflow_err_o), 32'd0);
    set_uniform(16'h00F0, 0);
    apply_stimulus(4'b1111, 4'b0000);
    set_uniform(16'h00F0, 1);
    apply_stimulus(4'b1111, 4'b0010);
    check_output("t4_col_done", 32'(col_done_o), 32'h2);
    check_output("t4_length", 32'(length_err_o), 32'd1);
    set_uniform(16'h00F0, 2);
    apply_stimulus(4'b1101, 4'b0000);
    set_uniform(16'h00F0, 3);
    apply_stimulus(4'b1101, 4'b1101);
    check_output("t4_done", 32'(done_o), 32'd1);
    check_output("t4_overflow", 32'(overflow_err_o), 32'd0);
    issue_read(4'd1, 16'h01F0);
    issue_read(4'd5, 16'h01F1);
    issue_read(4'd9, 16'h01E2);
    issue_read(4'd13, 16'h01E3);

    // 5: read of address 5 in the same cycle column 1 writes it.
    $display("[TB] read during write");
    arm();
    for (int c = 0; c < N; c++) stim_data[c] = 16'h0000;
    stim_data[1] = 16'h0055;
    apply_stimulus(4'b0010, 4'b0000);
    stim_data[1] = 16'h00AA;
    queue_read(4'd5, 16'h01F1);
    apply_stimulus(4'b0010, 4'b0000);
    issue_read(4'd5, 16'h00AA);
    issue_read(4'd1, 16'h0055);
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < N; c++) stim_data[c] = 16'h0077;
      apply_stimulus(4'b1101, 4'b0000);
    end
    check_output("t5_busy", 32'(busy_o), 32'd1);

    // 6: reset mid-collection, then a full stream from scratch.
    $display("[TB] reset mid-collection");
    rstn_i = 1'b0;
    #2;
    check_output("t6_rst_busy", 32'(busy_o), 32'd0);
    check_output("t6_rst_col_done", 32'(col_done_o), 32'd0);
    rstn_i = 1'b1;
    tick();
    check_output("t6_idle_busy", 32'(busy_o), 32'd0);
    arm();
    for (int k = 0; k < N; k++) begin
      set_uniform(16'h00A0, k);
      apply_stimulus(4'b1111, (k == 3) ? 4'b1111 : 4'b0000);
      check_output("t6_col_done", 32'(col_done_o), (k == 3) ? 32'hF : 32'h0);
      check_output("t6_done", 32'(done_o), (k == 3) ? 32'd1 : 32'd0);
    end
    check_output("t6_overflow", 32'(overflow_err_o), 32'd0);
    check_output("t6_length", 32'(length_err_o), 32'd0);
    read_all(16'h00A0);

    // Drain outstanding reads, bounded.
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) tick();
    check_output("reads_drained", 32'(exp_q.size()), 32'd0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_output_collector.md
Name: systolic_output_collector

Overview:
Drain-side counterpart of the column input queue. Captures result words emerging from the N bottom-edge PEs of the systolic array, using per-column valid/last strobes. Writes them into an N*N result buffer in the same layout the input queue reads, where column c element k sits at address c + N*k. Signals completion and exposes a registered read port for the host/next stage.

Parameters:
N, 8, systolic array dimension (columns, and elements per column)
DATA_WIDTH, 32, result word width
ADDR_WIDTH, $clog2(N*N), derived: result buffer address width
COUNT_WIDTH, $clog2(N+1), derived: per-column element counter width

Ports:
clk_i  input  1  clock
rstn_i  input  1  reset, asynchronous, active-low
start_i  input  1  arm collection; clears counters and error flags
data_i  input  DATA_WIDTH x N (unpacked [0:N-1])  result words from bottom-edge PEs
valid_i  input  N  per-column result valid
last_i  input  N  per-column last marker, qualified by valid_i
rd_en_i  input  1  read request
rd_addr_i  input  ADDR_WIDTH  read address
rd_data_o  output  DATA_WIDTH  read data, 1 cycle after rd_en_i
rd_valid_o  output  1  rd_data_o valid strobe
busy_o  output  1  high in COLLECT
done_o  output  1  one-cycle pulse on COLLECT->DONE
col_done_o  output  N  per-column complete flags
overflow_err_o  output  1  sticky: valid on an already-complete column
length_err_o  output  1  sticky: last_i seen with element count != N-1

Behaviour:
- Reset values: rd_data_o=0, rd_valid_o=0, busy_o=0, done_o=0, col_done_o=0, both error flags=0. All column counters=0, state=IDLE. Buffer contents are not cleared by reset.
- States: IDLE, COLLECT, DONE.
  - IDLE/DONE + start_i -> COLLECT: next cycle, counters=0, col_done=0, errors=0.
  - COLLECT -> DONE when all col_done bits are set, including bits set this cycle. done_o pulses in the cycle DONE is entered.
  - start_i in COLLECT is ignored.
- Capture happens only in COLLECT. Column c accepts a word when valid_i[c] and !col_done[c]:
  - write buffer[c + N*count[c]] <= data_i[c]
  - count[c] increments
  - col_done[c] sets if count[c]==N-1 or last_i[c]
  - length_err sets if last_i[c] and count[c]!=N-1
- All N columns may write in the same cycle. Their addresses are distinct by construction, so the buffer is N write ports plus 1 read port.
- valid_i[c] with col_done[c] set: word dropped, overflow_err_o sets.
- valid_i in IDLE or DONE: ignored, no error.
- last_i without valid_i: ignored.
- Address arithmetic is computed at ADDR_WIDTH. count[c] never exceeds N, so there is no wrap.
- Read port operates in any state:
  - rd_en_i at cycle t -> rd_data_o = buffer[rd_addr_i] and rd_valid_o=1 at t+1.
  - When rd_en_i is low, rd_valid_o=0 next cycle and rd_data_o holds its value.
  - Read and write to the same address in the same cycle: read returns the old contents.
  - rd_addr_i >= N*N returns 0, with rd_valid_o still asserted.
- Reset mid-COLLECT returns to IDLE immediately. Partially written buffer contents remain; counters are lost.
- busy_o = (state==COLLECT), registered with state.

Test Plan:
- N=4, start_i, then each column c gets 4 valid words 16'hC0+k on consecutive cycles, last_i on k=3 -> done_o pulses once 1 cycle after final write. Reading addr c+4k returns 16'hC0+k with 1-cycle latency. Errors stay 0.
- Skewed arrival: column c begins c cycles after column 0 (systolic diagonal) -> col_done_o bits set in order 0001, 0011, 0111, 1111; DONE is entered only on the last bit.
- Extra valid on column 2 after its 4th word -> overflow_err_o=1, buffer addr 2..14 unchanged, done_o timing unaffected.
- last_i[1] with 2nd word (count=1) -> col_done_o[1]=1, length_err_o=1, addresses 9 and 13 not written.
- Same-cycle read of addr 5 while column 1 writes its 2nd word 0xAA -> returns prior value; a read next cycle returns 0xAA.
- Assert rstn_i low mid-collection after 2 words per column, then start_i -> counters restart at 0. A full 4-word stream completes normally and overwrites addresses 0..15.
